// File: rtl/scandoubler_pkg.sv
// Shared constants, read-side state type and width helpers for the
// clock-enable VGA scandoubler.
package scandoubler_pkg;

   localparam int COLW_DEF    = 3;
   localparam int DEPTH_DEF   = 1024;
   localparam int HSYNC_W_DEF = 96;

   // Read-side copy state: IDLE means "done", COPY0/COPY1 are the two halves.
   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_COPY0 = 2'd1,
      RD_COPY1 = 2'd2
   } rd_state_t;

   // Counter width for a line of up to depth pixels (never narrower than 1).
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Width of one stored pixel word {r, g, b}.
   function automatic int pix_width(input int colw);
      return 3 * colw;
   endfunction

endpackage

// File: rtl/scandoubler_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM with one write port and one
// synchronous read port. The bank bit is the address MSB, so the array holds
// two lines of 2**AW words each.
module scandoubler_linebuf
   import scandoubler_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 9
)(
   input  logic          clk,
   input  logic          we,
   input  logic [AW:0]   waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW:0]   raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(2**(AW+1))-1];

   // Write port: one pixel per input strobe.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port: registered output, one clk of latency.
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/vga_scandoubler_ce.sv
// Single-clock scandoubler: each 15 kHz input line is written into one bank
// of a ping-pong buffer at the pixel strobe rate and read back twice from the
// other bank at the full clk rate, producing 31 kHz VGA timing.
module vga_scandoubler_ce
   import scandoubler_pkg::*;
#(
   parameter int COLW    = COLW_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int HSYNC_W = HSYNC_W_DEF
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            ce_in,
   input  logic [COLW-1:0] ri,
   input  logic [COLW-1:0] gi,
   input  logic [COLW-1:0] bi,
   input  logic            hsync_ext_n,
   input  logic            vsync_ext_n,
   input  logic            scanlines,
   output logic [COLW-1:0] ro,
   output logic [COLW-1:0] go,
   output logic [COLW-1:0] bo,
   output logic            hsync,
   output logic            vsync
);

   localparam int AW = addr_width(DEPTH);
   localparam int PW = pix_width(COLW);

   localparam logic [AW-1:0] CNT_ONE = AW'(1);
   localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH - 1);
   localparam logic [AW-1:0] HS_LEN  = AW'(HSYNC_W);

   // ------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------
   logic          hs_prev;
   logic          hs_edge;
   logic          wbank;
   logic [AW-1:0] wcnt;
   logic [AW-1:0] linelen;
   logic          w_bank_eff;
   logic [AW-1:0] w_cnt_eff;

   // Falling edge of input hsync between two consecutive strobe samples.
   assign hs_edge = ce_in & hs_prev & ~hsync_ext_n;

   // The sample that carries the edge is pixel 0 of the new line, so it is
   // written to slot 0 of the freshly selected bank. This makes linelen equal
   // the number of strobes per input line.
   always_comb begin
      w_bank_eff = hs_edge ? ~wbank : wbank;
      w_cnt_eff  = hs_edge ? '0 : wcnt;
   end

   // Write counter, bank select and captured line length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_prev <= 1'b1;
         wcnt    <= '0;
         wbank   <= 1'b0;
         linelen <= '0;
      end else if (ce_in) begin
         hs_prev <= hsync_ext_n;
         if (hs_edge) begin
            linelen <= (wcnt == '0) ? CNT_ONE : wcnt;
            wcnt    <= CNT_ONE;
            wbank   <= ~wbank;
         end else if (wcnt != CNT_MAX) begin
            wcnt <= wcnt + CNT_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read side FSM (IDLE / COPY0 / COPY1)
   // ------------------------------------------------------------------
   rd_state_t     state;
   rd_state_t     state_nx;
   logic [AW-1:0] rcnt;
   logic [AW-1:0] rcnt_nx;
   logic          rbank;
   logic          rbank_nx;
   logic          vsync_lat;
   logic          vsync_lat_nx;
   logic          rd_last;

   assign rd_last = (rcnt == (linelen - CNT_ONE));

   // Read-side state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RD_IDLE;
         rcnt      <= '0;
         rbank     <= 1'b0;
         vsync_lat <= 1'b1;
      end else begin
         state     <= state_nx;
         rcnt      <= rcnt_nx;
         rbank     <= rbank_nx;
         vsync_lat <= vsync_lat_nx;
      end
   end

   // Next state: an input hsync edge always restarts copy 0, even when it
   // lands on an rcnt wrap or in the middle of a copy.
   always_comb begin
      state_nx     = state;
      rcnt_nx      = rcnt;
      rbank_nx     = rbank;
      vsync_lat_nx = vsync_lat;
      if (hs_edge) begin
         state_nx     = RD_COPY0;
         rcnt_nx      = '0;
         rbank_nx     = wbank;
         vsync_lat_nx = vsync_ext_n;
      end else begin
         case (state)
            RD_COPY0: begin
               if (rd_last) begin
                  state_nx = RD_COPY1;
                  rcnt_nx  = '0;
               end else begin
                  rcnt_nx = rcnt + CNT_ONE;
               end
            end
            RD_COPY1: begin
               if (rd_last) begin
                  state_nx = RD_IDLE;
               end else begin
                  rcnt_nx = rcnt + CNT_ONE;
               end
            end
            default: begin
               state_nx = state;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Line buffer
   // ------------------------------------------------------------------
   logic [PW-1:0] rd_data;

   scandoubler_linebuf #(
      .AW (AW),
      .DW (PW)
   ) u_linebuf (
      .clk   (clk),
      .we    (ce_in),
      .waddr ({w_bank_eff, w_cnt_eff}),
      .wdata ({ri, gi, bi}),
      .raddr ({rbank, rcnt}),
      .rdata (rd_data)
   );

   // ------------------------------------------------------------------
   // Output pipeline: stage 0 is the RAM address cycle, stage 1 lines up
   // with RAM data, stage 2 is the output register.
   // ------------------------------------------------------------------
   logic done0;
   logic half0;
   logic hs0;
   logic vs0;
   logic vs_hold;
   logic done1;
   logic half1;
   logic hs1;
   logic vs1;

   // Stage-0 control: sync pulse at the head of each half, vsync refreshed
   // only when a half starts.
   always_comb begin
      done0 = (state == RD_IDLE);
      half0 = (state != RD_COPY0);
      hs0   = ~(~done0 && (rcnt < HS_LEN));
      vs0   = (~done0 && (rcnt == '0)) ? vsync_lat : vs_hold;
   end

   // Stage-1 control registers, aligned with the RAM read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_hold <= 1'b1;
         done1   <= 1'b1;
         half1   <= 1'b1;
         hs1     <= 1'b1;
         vs1     <= 1'b1;
      end else begin
         vs_hold <= vs0;
         done1   <= done0;
         half1   <= half0;
         hs1     <= hs0;
         vs1     <= vs0;
      end
   end

   logic [COLW-1:0] r_pix;
   logic [COLW-1:0] g_pix;
   logic [COLW-1:0] b_pix;
   logic [COLW-1:0] r_nx;
   logic [COLW-1:0] g_nx;
   logic [COLW-1:0] b_nx;
   logic            dim;

   // Colour for the output register: black when done, halved on the second
   // copy when scanline dimming is selected.
   always_comb begin
      r_pix = rd_data[PW-1 -: COLW];
      g_pix = rd_data[2*COLW-1 -: COLW];
      b_pix = rd_data[COLW-1:0];
      dim   = scanlines & half1;
      r_nx  = '0;
      g_nx  = '0;
      b_nx  = '0;
      if (!done1) begin
         r_nx = dim ? (r_pix >> 1) : r_pix;
         g_nx = dim ? (g_pix >> 1) : g_pix;
         b_nx = dim ? (b_pix >> 1) : b_pix;
      end
   end

   // Stage-2 output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ro    <= '0;
         go    <= '0;
         bo    <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         ro    <= r_nx;
         go    <= g_nx;
         bo    <= b_nx;
         hsync <= hs1;
         vsync <= vs1;
      end
   end

endmodule

// File: tb/tb_vga_scandoubler_ce.sv
// Bench for vga_scandoubler_ce: two instances (DEPTH 1024 / HSYNC_W 96 and
// DEPTH 16 / HSYNC_W 4) share one stimulus stream. A line-level model keeps
// the captured input lines and derives each output cycle from the time of
// the input hsync edge that started it.
module tb_vga_scandoubler_ce;

   localparam int NI = 2;

   int dep [NI] = '{1024, 16};
   int hsw [NI] = '{96, 4};

   logic       clk = 1'b0;
   logic       rst;
   logic       ce_in;
   logic [2:0] ri, gi, bi;
   logic       hsync_ext_n;
   logic       vsync_ext_n;
   logic       scanlines;

   logic [2:0] ro_a, go_a, bo_a, ro_b, go_b, bo_b;
   logic       hs_a, vs_a, hs_b, vs_b;

   always #5 clk = ~clk;

   vga_scandoubler_ce #(.COLW(3), .DEPTH(1024), .HSYNC_W(96)) dut_a (
      .clk (clk), .rst (rst), .ce_in (ce_in),
      .ri (ri), .gi (gi), .bi (bi),
      .hsync_ext_n (hsync_ext_n), .vsync_ext_n (vsync_ext_n),
      .scanlines (scanlines),
      .ro (ro_a), .go (go_a), .bo (bo_a), .hsync (hs_a), .vsync (vs_a)
   );

   vga_scandoubler_ce #(.COLW(3), .DEPTH(16), .HSYNC_W(4)) dut_b (
      .clk (clk), .rst (rst), .ce_in (ce_in),
      .ri (ri), .gi (gi), .bi (bi),
      .hsync_ext_n (hsync_ext_n), .vsync_ext_n (vsync_ext_n),
      .scanlines (scanlines),
      .ro (ro_b), .go (go_b), .bo (bo_b), .hsync (hs_b), .vsync (vs_b)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model state: line being captured, line being shown (cur) and
   // the line shown before it (prev, still visible for 2 clk after an edge).
   logic [8:0] wbuf [NI][1024];
   logic [8:0] cbuf [NI][1024];
   logic [8:0] pbuf [NI][1024];
   int         wn   [NI];
   bit         cv   [NI];
   bit         pv   [NI];
   int         ct   [NI];
   int         pt   [NI];
   int         cl   [NI];
   int         pl   [NI];
   logic       cvs  [NI];
   logic       pvs  [NI];
   logic       m_hs_prev;
   logic [8:0] exp_pix [NI];
   logic       exp_hs  [NI];
   logic       exp_vs  [NI];

   task automatic check_one(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_clock(input logic ce, input logic hs_n, input logic vs_n,
                              input logic [8:0] pix, input logic scan);
      int len, slot, d, kk, t, l, sel;
      logic v;
      logic [8:0] p;
      logic [2:0] r, g, b;
      cyc++;
      if (rst) begin
         m_hs_prev = 1'b1;
         for (int k = 0; k < NI; k++) begin
            wn[k] = 0; cv[k] = 1'b0; pv[k] = 1'b0;
         end
      end else if (ce) begin
         if (m_hs_prev && !hs_n) begin
            for (int k = 0; k < NI; k++) begin
               len = (wn[k] < dep[k] - 1) ? wn[k] : dep[k] - 1;
               if (len < 1) len = 1;
               for (int i = 0; i < 1024; i++) begin
                  pbuf[k][i] = cbuf[k][i];
                  cbuf[k][i] = wbuf[k][i];
               end
               pv[k] = cv[k]; pt[k] = ct[k]; pl[k] = cl[k]; pvs[k] = cvs[k];
               cv[k] = 1'b1; ct[k] = cyc; cl[k] = len; cvs[k] = vs_n;
               wn[k] = 0;
            end
         end
         for (int k = 0; k < NI; k++) begin
            slot = (wn[k] < dep[k] - 1) ? wn[k] : dep[k] - 1;
            wbuf[k][slot] = pix;
            wn[k]++;
         end
         m_hs_prev = hs_n;
      end
      for (int k = 0; k < NI; k++) begin
         sel = 0;
         if (cv[k] && cyc >= ct[k] + 2) sel = 1;
         else if (pv[k] && cyc >= pt[k] + 2) sel = 2;
         if (sel == 0) begin
            exp_pix[k] = 9'h0; exp_hs[k] = 1'b1; exp_vs[k] = 1'b1;
         end else begin
            t = (sel == 1) ? ct[k] : pt[k];
            l = (sel == 1) ? cl[k] : pl[k];
            v = (sel == 1) ? cvs[k] : pvs[k];
            d = cyc - t - 2;
            if (d < 2 * l) begin
               kk = d % l;
               p  = (sel == 1) ? cbuf[k][kk] : pbuf[k][kk];
               r = p[8:6]; g = p[5:3]; b = p[2:0];
               if (d >= l && scan) begin
                  r = r / 2; g = g / 2; b = b / 2;
               end
               exp_pix[k] = {r, g, b};
               exp_hs[k]  = (kk >= hsw[k]);
               exp_vs[k]  = v;
            end else begin
               exp_pix[k] = 9'h0; exp_hs[k] = 1'b1; exp_vs[k] = v;
            end
         end
      end
   endtask

   task automatic check_outputs();
      check_one("rgb_a",   {ro_a, go_a, bo_a}, exp_pix[0]);
      check_one("hsync_a", {8'h0, hs_a},       {8'h0, exp_hs[0]});
      check_one("vsync_a", {8'h0, vs_a},       {8'h0, exp_vs[0]});
      check_one("rgb_b",   {ro_b, go_b, bo_b}, exp_pix[1]);
      check_one("hsync_b", {8'h0, hs_b},       {8'h0, exp_hs[1]});
      check_one("vsync_b", {8'h0, vs_b},       {8'h0, exp_vs[1]});
   endtask

   task automatic check_reset_values(input string tag);
      check_one({tag, "_rgb_a"}, {ro_a, go_a, bo_a}, 9'h0);
      check_one({tag, "_hs_a"},  {8'h0, hs_a},       9'h1);
      check_one({tag, "_vs_a"},  {8'h0, vs_a},       9'h1);
      check_one({tag, "_rgb_b"}, {ro_b, go_b, bo_b}, 9'h0);
      check_one({tag, "_hs_b"},  {8'h0, hs_b},       9'h1);
      check_one({tag, "_vs_b"},  {8'h0, vs_b},       9'h1);
   endtask

   task automatic clk_step(input logic ce, input logic hs_n, input logic vs_n, input logic [8:0] pix);
      ce_in = ce; hsync_ext_n = hs_n; vsync_ext_n = vs_n; {ri, gi, bi} = pix;
      @(posedge clk);
      model_clock(ce, hs_n, vs_n, pix, scanlines);
      @(negedge clk);
      check_outputs();
   endtask

   // Pixels from..to-1 of a line, one strobe every 2 clk; input hsync is low
   // for pixels 0..7. mode: 0 ramp, 1 constant 110, 2 random, 3 index value.
   task automatic drive_line(input int from, input int to, input int mode, input logic vs_n);
      logic [8:0] p;
      logic       h;
      for (int i = from; i < to; i++) begin
         case (mode)
            0:       p = {3{3'(i % 8)}};
            1:       p = 9'b110_110_110;
            2:       p = 9'($urandom);
            default: p = 9'(i);
         endcase
         h = (i < 8) ? 1'b0 : 1'b1;
         clk_step(1'b1, h, vs_n, p);
         clk_step(1'b0, h, vs_n, p);
      end
   endtask

   initial begin
      rst = 1'b1; ce_in = 1'b0; hsync_ext_n = 1'b1; vsync_ext_n = 1'b1;
      scanlines = 1'b0; {ri, gi, bi} = 9'h0;
      @(negedge clk);
      check_reset_values("por");
      repeat (4) clk_step(1'b0, 1'b1, 1'b1, 9'h0);
      rst = 1'b0;

      // Preamble with hsync high: output must stay idle, no edge yet.
      drive_line(8, 20, 0, 1'b1);

      // Steady ramp lines.
      scanlines = 1'b0;
      repeat (3) drive_line(0, 400, 0, 1'b1);

      // Scanline dimming on a constant colour.
      scanlines = 1'b1;
      repeat (2) drive_line(0, 400, 1, 1'b1);

      // Random colours, lengths and dimming.
      repeat (3) begin
         scanlines = 1'($urandom_range(0, 1));
         drive_line(0, $urandom_range(150, 450), 2, 1'b1);
      end

      // Early hsync: 400-pixel line followed by 300-pixel lines.
      scanlines = 1'b0;
      drive_line(0, 400, 0, 1'b1);
      drive_line(0, 300, 0, 1'b1);
      drive_line(0, 300, 2, 1'b1);

      // Vsync low for three input lines.
      for (int i = 0; i < 5; i++) begin
         drive_line(0, 120, 2, (i >= 1 && i <= 3) ? 1'b0 : 1'b1);
      end

      // Overflow on the DEPTH=16 instance: 20-pixel lines valued 0..19.
      repeat (3) drive_line(0, 20, 3, 1'b1);

      // Reset in the middle of a line.
      drive_line(0, 400, 0, 1'b1);
      drive_line(0, 200, 0, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_values("rst_mid");
      repeat (2) begin
         clk_step(1'b1, 1'b1, 1'b1, 9'h1ff);
         clk_step(1'b0, 1'b1, 1'b1, 9'h1ff);
      end
      rst = 1'b0;
      drive_line(200, 400, 0, 1'b1);
      repeat (2) drive_line(0, 400, 2, 1'b1);

      // Let the last copies drain with no further edge.
      drive_line(8, 420, 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
